vector_lane_mux_pipe: RTL
=========================

// Module: vector_lane_mux_pipe
// PURPOSE
//  Parametrised, registered INPUTS:1 selector applied independently to each of LANES vector lanes.
//  Inputs and output use a valid/ready handshake; the output is held in a 2-entry skid buffer.
//  Used in the vector datapath ahead of the alpha-composition units to route operand lanes.
//  Supports per-lane select and broadcast select; out-of-range selects yield zero.
// PARAMETERS
//  N       32  lane data width, bits (>=1)
//  LANES   4   vector lanes (>=1)
//  INPUTS  8   candidate source vectors (>=2, need not be a power of 2)
//  SELW    $clog2(INPUTS)  per-lane select width (derived, localparam)
// PORTS
//  clk        in   1                     rising-edge clock
//  rst_n      in   1                     asynchronous active-low reset
//  in_valid   in   1                     input beat valid
//  in_ready   out  1                     block can accept a beat (registered)
//  in_data    in   INPUTS*LANES*N        source k, lane l = in_data[(k*LANES+l)*N +: N]
//  in_sel     in   LANES*SELW            lane l select = in_sel[l*SELW +: SELW]
//  in_bcast   in   1                     1: every lane uses the lane-0 select
//  out_valid  out  1                     output beat valid
//  out_ready  in   1                     consumer accepts output beat
//  out_data   out  LANES*N               lane l = selected source, lane l
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_data=0, in_ready=1, skid empty, state EMPTY.
//  Accept: in_valid & in_ready at a rising edge. Emit: out_valid & out_ready at a rising edge.
//  Selection (combinational, per lane l): s = in_bcast ? sel[0] : sel[l];
//   if s < INPUTS, lane_out = in_data source s, lane l; else lane_out = 0 (no X).
//  Latency: an accepted beat is on out_data on the cycle after acceptance (1 cycle).
//  Storage: main register (drives out_*) plus one skid register.
//  States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
//   EMPTY: accept -> main<=beat, ONE.
//   ONE:   accept & emit -> main<=beat, ONE; accept & !emit -> skid<=beat, FULL;
//          !accept & emit -> EMPTY; else hold.
//   FULL:  in_ready=0 (no accept); emit -> main<=skid, ONE; else hold.
//  in_ready = (state != FULL), driven from a flop; it never depends combinationally on out_ready.
//  out_valid = (state != EMPTY); out_data/out_valid stay stable while out_valid & !out_ready.
//  in_valid while in_ready=0: ignored; the source must hold the beat (AXI-style rules).
//  Order preserved: beats leave in acceptance order; none dropped or duplicated.
//  Skid register updates only on its capture; main holds its value when not loading (no zeroing).
//  Reset mid-operation: all buffered beats discarded immediately; the next cycle is EMPTY.
//  Throughput: 1 beat/cycle when out_ready is held high.
// TESTING
//  1 Per-lane: N=32,LANES=4,INPUTS=8; source k lane l = {k,l}; sel={7,0,3,5}, bcast=0
//    -> next cycle out lanes = {7,0},{0,1},{3,2},{5,3}, out_valid=1.
//  2 Broadcast: sel lane0=6, other lanes=1, bcast=1 -> out lanes = {6,0},{6,1},{6,2},{6,3}.
//  3 Out of range: INPUTS=5, lane2 sel=6 -> lane2=0, other lanes correct.
//  4 Backpressure: out_ready=0, send 2 beats A,B -> in_ready=0 after B, out=A held stable;
//    out_ready=1 -> A then B on consecutive cycles, in_ready=1 again.
//  5 Streaming: 100 random beats, random in_valid/out_ready -> scoreboard exact in-order match, no X.
//  6 Reset in FULL: assert rst_n=0 mid-cycle -> out_valid=0, out_data=0, in_ready=1 without a clock edge.

Source files
------------

// File: rtl/vector_lane_mux_pipe.sv
// rtl/vector_lane_mux_pipe.sv - per-lane INPUTS:1 selector with valid/ready and 2-entry skid output
module vector_lane_mux_pipe #(
    parameter  int N      = 32,
    parameter  int LANES  = 4,
    parameter  int INPUTS = 8,
    localparam int SELW   = $clog2(INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INPUTS*LANES*N-1:0] in_data,
    input  logic [LANES*SELW-1:0]     in_sel,
    input  logic                      in_bcast,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*N-1:0]        out_data
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [LANES*N-1:0] sel_data;
    logic [LANES*N-1:0] main_data;
    logic [LANES*N-1:0] skid_data;
    logic [SELW-1:0]    lane_sel;
    logic               accept;
    logic               emit;
    logic               load_main;
    logic               load_skid;
    logic               main_from_skid;

    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;

    // Compare against every legal source index so that selects >= INPUTS match nothing and yield zero.
    always_comb begin
        sel_data = '0;
        lane_sel = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sel = in_bcast ? in_sel[0 +: SELW] : in_sel[l*SELW +: SELW];
            for (int k = 0; k < INPUTS; k++) begin
                if (lane_sel == SELW'(k)) begin
                    sel_data[l*N +: N] = in_data[(k*LANES+l)*N +: N];
                end
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so it never follows out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
            if (load_main) begin
                main_data <= sel_data;
            end else if (main_from_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= sel_data;
            end
        end
    end

endmodule
